instr_issue_sequencer: RTL and testbench

- Hardware successor to the file-driven instruction feeder used around the 8-bit common-bus CPU.
- Buffers instructions in a parametrised FIFO.
- Presents each instruction to the CPU's instruction input for an opcode-dependent number of cycles (short class vs long class).
- Supports a stall input that freezes the current hold window.
- Sits between the instruction source (host loader or ROM walker) and the CPU core.

---
 rtl/issue_seq_pkg.sv | 29 ++
 rtl/issue_seq_fifo.sv | 77 +++++++
 rtl/instr_issue_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_issue_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_seq_pkg.sv
// Shared types, default timing constants and the hold-length helper for
// the instruction issue sequencer.
package issue_seq_pkg;

  // Sequencer FSM: waiting for work, or presenting an instruction.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } issue_state_e;

  localparam int DEF_SHORT_OPCODE = 1;
  localparam int DEF_SHORT_CYCLES = 7;
  localparam int DEF_LONG_CYCLES  = 9;

  // Number of cycles an instruction with the given opcode is presented.
  function automatic int hold_cycles(input int opcode,
                                     input int short_opcode,
                                     input int short_cycles,
                                     input int long_cycles);
    int cycles;
    if (opcode == short_opcode) begin
      cycles = short_cycles;
    end else begin
      cycles = long_cycles;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/issue_seq_fifo.sv
// Synchronous instruction FIFO. DEPTH must be a power of two so the
// read/write pointers wrap naturally. Push when full and pop when empty
// are ignored. The head entry is visible combinationally.
module issue_seq_fifo #(
  parameter  int INSTR_W = 14,
  parameter  int DEPTH   = 8,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output logic [INSTR_W-1:0] head
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == {CNT_W{1'b0}});
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards every stored entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {INSTR_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Instruction issue sequencer: buffers instructions and presents each one
// to the CPU for an opcode-dependent number of cycles, with stall support.
// Optional macro ISSUE_SEQ_STATS_EN adds issued_count / stall_cycles ports.
module instr_issue_sequencer
  import issue_seq_pkg::*;
#(
  parameter  int INSTR_W      = 14,
  parameter  int OPCODE_W     = 4,
  parameter  int DEPTH        = 8,
  parameter  int SHORT_OPCODE = DEF_SHORT_OPCODE,
  parameter  int SHORT_CYCLES = DEF_SHORT_CYCLES,
  parameter  int LONG_CYCLES  = DEF_LONG_CYCLES,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_active,
  output logic               issue_start,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               idle
`ifdef ISSUE_SEQ_STATS_EN
  ,
  output logic [15:0]        issued_count,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int MAX_CYC = (SHORT_CYCLES > LONG_CYCLES) ? SHORT_CYCLES : LONG_CYCLES;
  localparam int HOLD_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  issue_state_e       state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic               issue_start_q, issue_start_d;
  logic               load_s;
  logic               push_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   count_s;
  logic [INSTR_W-1:0] head_s;

  // No full-bypass: readiness comes only from the registered occupancy.
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;

  issue_seq_fifo #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (load_s),
    .wr_data (in_instr),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s),
    .head    (head_s)
  );

  // FSM next-state: decide on a load, count the hold window down, honour stall.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    instr_out_d   = instr_out_q;
    issue_start_d = 1'b0;
    load_s        = 1'b0;
    case (state_q)
      IDLE: begin
        // stall has no effect here; any buffered entry loads at once.
        if (!empty_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      HOLD: begin
        if (stall) begin
          hold_cnt_d = hold_cnt_q;
        end else if (hold_cnt_q != {HOLD_W{1'b0}}) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end else if (!empty_s) begin
          // Back-to-back load: next window starts without a gap cycle.
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load_s) begin
      state_d       = HOLD;
      instr_out_d   = head_s;
      hold_cnt_d    = HOLD_W'(hold_cycles(int'(head_s[OPCODE_W-1:0]), SHORT_OPCODE,
                                          SHORT_CYCLES, LONG_CYCLES) - 1);
      issue_start_d = 1'b1;
    end else begin
      issue_start_d = 1'b0;
    end
  end

  // FSM and presentation registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hold_cnt_q    <= {HOLD_W{1'b0}};
      instr_out_q   <= {INSTR_W{1'b0}};
      issue_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      instr_out_q   <= instr_out_d;
      issue_start_q <= issue_start_d;
    end
  end

  assign instr_out    = instr_out_q;
  assign issue_start  = issue_start_q;
  assign instr_active = (state_q == HOLD);
  assign fifo_count   = count_s;
  assign idle         = (state_q == IDLE) && empty_s;

`ifdef ISSUE_SEQ_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] stalls_q, stalls_d;

  // Statistics: issued wraps, stalled-cycle counter saturates.
  always_comb begin
    issued_d = issued_q;
    stalls_d = stalls_q;
    if (load_s) begin
      issued_d = issued_q + 16'd1;
    end else begin
      issued_d = issued_q;
    end
    if ((state_q == HOLD) && stall && (stalls_q != 16'hFFFF)) begin
      stalls_d = stalls_q + 16'd1;
    end else begin
      stalls_d = stalls_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= 16'd0;
      stalls_q <= 16'd0;
    end else begin
      issued_q <= issued_d;
      stalls_q <= stalls_d;
    end
  end

  assign issued_count = issued_q;
  assign stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench for instr_issue_sequencer: a cycle scoreboard holds
// accepted instructions and predicts loads, windows and occupancy; directed
// sequences cover the single, back-to-back, full, stall, reset and wrap cases.
module tb_instr_issue_sequencer;

  localparam int TB_DEPTH = 8;
  localparam int CNT_W    = $clog2(TB_DEPTH + 1);

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [13:0]      in_instr;
  logic             stall;
  logic [13:0]      instr_out;
  logic             instr_active;
  logic             issue_start;
  logic [CNT_W-1:0] fifo_count;
  logic             idle;
`ifdef ISSUE_SEQ_STATS_EN
  logic [15:0]      issued_count;
  logic [15:0]      stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  instr_issue_sequencer #(.DEPTH(TB_DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .stall        (stall),
    .instr_out    (instr_out),
    .instr_active (instr_active),
    .issue_start  (issue_start),
    .fifo_count   (fifo_count),
    .idle         (idle)
`ifdef ISSUE_SEQ_STATS_EN
    ,
    .issued_count (issued_count),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_hold(input logic [13:0] x);
    return (x[3:0] == 4'd1) ? 7 : 9;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard / reference model state
  logic [13:0] m_q[$];
  logic [13:0] m_out;
  bit          m_active, m_start, m_pend, m_nxt_load;
  int          m_left, m_lvl;
  int          run, last_run, starts;

  initial begin
    m_out = 14'd0; m_active = 1'b0; m_start = 1'b0; m_pend = 1'b0; m_nxt_load = 1'b0;
    m_left = 0; m_lvl = 0; run = 0; last_run = 0; starts = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        m_q.delete();
        m_out = 14'd0; m_active = 1'b0; m_pend = 1'b0; m_nxt_load = 1'b0;
        m_left = 0; m_lvl = 0; run = 0;
      end else begin
        m_start = m_nxt_load;
        if (m_start) begin
          m_out    = m_q.pop_front();
          m_left   = exp_hold(m_out);
          m_active = 1'b1;
        end else if (m_active && m_left == 0) begin
          m_active = 1'b0;
        end
        m_lvl = m_lvl + (m_pend ? 1 : 0) - (m_start ? 1 : 0);
        check_eq("issue_start", 32'(issue_start), 32'(m_start));
        check_eq("instr_active", 32'(instr_active), 32'(m_active));
        check_eq("instr_out", 32'(instr_out), 32'(m_out));
        check_eq("fifo_count", 32'(fifo_count), 32'(m_lvl));
        check_eq("in_ready", 32'(in_ready), 32'(m_lvl < TB_DEPTH));
        check_eq("idle", 32'(idle), 32'(!m_active && m_lvl == 0));
        if (m_active && !stall) m_left--;
        m_pend = in_valid && (m_lvl < TB_DEPTH);
        if (m_pend) m_q.push_back(in_instr);
        m_nxt_load = (m_lvl > 0) && (!m_active || m_left == 0);
        if (instr_active) begin
          run++;
        end else if (run > 0) begin
          last_run = run;
          run = 0;
        end
        if (issue_start) starts++;
      end
    end
  end

  task automatic push_one(input logic [13:0] v);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = v;
    for (int i = 0; i < 60 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (idle) seen = 1'b1;
      else tick();
    end
    if (!seen) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, acc;
    bit seen;
    reset_n = 1'b0; in_valid = 1'b0; in_instr = 14'd0; stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_instr_out", 32'(instr_out), 32'd0);
    check_eq("rst_active", 32'(instr_active), 32'd0);
    check_eq("rst_start", 32'(issue_start), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_idle", 32'(idle), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single short instruction
    s0 = starts;
    push_one(14'h0001);
    tick();
    check_eq("t1_latency_start", 32'(issue_start), 32'd1);
    check_eq("t1_latency_out", 32'(instr_out), 32'h0001);
    repeat (6) tick();
    check_eq("t1_cycle7_active", 32'(instr_active), 32'd1);
    check_eq("t1_cycle7_idle", 32'(idle), 32'd0);
    tick();
    check_eq("t1_cycle8_idle", 32'(idle), 32'd1);
    check_eq("t1_retained_out", 32'(instr_out), 32'h0001);
    tick();
    check_eq("t1_window_len", 32'(last_run), 32'd7);
    check_eq("t1_starts", 32'(starts - s0), 32'd1);

    // Back-to-back 7/9/7
    s0 = starts;
    push_one(14'h0001);
    push_one(14'h0002);
    push_one(14'h0011);
    wait_idle(100);
    tick();
    check_eq("t2_active_run", 32'(last_run), 32'd23);
    check_eq("t2_starts", 32'(starts - s0), 32'd3);

    // Full FIFO while first long window runs
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = 14'h0A0 + 14'(acc);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check_eq("t3_accepted", 32'(acc), 32'd9);
    check_eq("t3_full_count", 32'(fifo_count), 32'd8);
    check_eq("t3_full_ready", 32'(in_ready), 32'd0);
    wait_idle(200);
    tick();

    // Stall mid-window
    apply_reset();
    push_one(14'h0002);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (issue_start) seen = 1'b1;
      else tick();
    end
    check_eq("t4_start_seen", 32'(seen), 32'd1);
    tick();
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_idle(50);
    tick();
    check_eq("t4_window_len", 32'(last_run), 32'd12);
`ifdef ISSUE_SEQ_STATS_EN
    check_eq("t4_stall_cycles", 32'(stall_cycles), 32'd3);
    check_eq("t4_issued", 32'(issued_count), 32'd1);
`endif

    // Reset mid-window with three buffered entries
    push_one(14'h0003);
    push_one(14'h0004);
    push_one(14'h0005);
    push_one(14'h0006);
    check_eq("t5_buffered", 32'(fifo_count), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("t5_instr_out", 32'(instr_out), 32'd0);
    check_eq("t5_active", 32'(instr_active), 32'd0);
    check_eq("t5_start", 32'(issue_start), 32'd0);
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    check_eq("t5_idle", 32'(idle), 32'd1);
    check_eq("t5_count", 32'(fifo_count), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    s0 = starts;
    repeat (15) tick();
    check_eq("t5_no_issue", 32'(starts - s0), 32'd0);
    check_eq("t5_idle_after", 32'(idle), 32'd1);

    // Stream 20 random instructions (pointer wrap)
    apply_reset();
    s0 = starts;
    for (int i = 0; i < 20; i++) begin
      push_one(14'($urandom));
    end
    wait_idle(400);
    tick();
    check_eq("t6_starts", 32'(starts - s0), 32'd20);
`ifdef ISSUE_SEQ_STATS_EN
    check_eq("t6_issued", 32'(issued_count), 32'd20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
